// File: rtl/stream_pack_reader.sv
// Packs narrow valid/ready beats little-endian into wide words and buffers them in a small FIFO.
// in_last closes a word early; the closed word carries per-lane keep bits and a last flag.
module stream_pack_reader #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned RATIO = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [IN_W-1:0]             in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [IN_W*RATIO-1:0]       out_data,
    output logic [RATIO-1:0]            out_keep,
    output logic                        out_last,
    output logic [$clog2(DEPTH):0]      fifo_level
);

    localparam int unsigned OUT_W = IN_W * RATIO;
    localparam int unsigned IDX_W = $clog2(RATIO);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [IDX_W-1:0] idx;
    logic [OUT_W-1:0] pack_data;
    logic [RATIO-1:0] pack_keep;

    logic [OUT_W-1:0] mem_data [DEPTH];
    logic [RATIO-1:0] mem_keep [DEPTH];
    logic             mem_last [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             beat_acc;
    logic             closing;
    logic             push;
    logic             pop;
    logic [OUT_W-1:0] word_data;
    logic [RATIO-1:0] word_keep;

    assign in_ready  = (fifo_level != LVL_W'(DEPTH));
    assign out_valid = (fifo_level != '0);
    assign beat_acc  = in_valid && in_ready;
    assign closing   = (idx == IDX_W'(RATIO - 1)) || in_last;
    assign push      = beat_acc && closing;
    assign pop       = out_valid && out_ready;

    // Pack register with the current beat merged into its lane.
    always_comb begin
        word_data = pack_data;
        word_keep = pack_keep;
        for (int k = 0; k < RATIO; k++) begin
            if (idx == IDX_W'(k)) begin
                word_data[k*IN_W +: IN_W] = in_data;
                word_keep[k]              = 1'b1;
            end
        end
    end

    // Lane index and partial-word accumulation; cleared once the word is closed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            pack_data <= '0;
            pack_keep <= '0;
        end else if (beat_acc) begin
            if (closing) begin
                idx       <= '0;
                pack_data <= '0;
                pack_keep <= '0;
            end else begin
                idx       <= idx + IDX_W'(1);
                pack_data <= word_data;
                pack_keep <= word_keep;
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted by fifo_level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= word_data;
            mem_keep[wr_ptr] <= word_keep;
            mem_last[wr_ptr] <= in_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    assign out_data = out_valid ? mem_data[rd_ptr] : '0;
    assign out_keep = out_valid ? mem_keep[rd_ptr] : '0;
    assign out_last = out_valid ? mem_last[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_stream_pack_reader.sv
// Randomized and directed bench for stream_pack_reader against a queue-based word model.
module tb_stream_pack_reader;

    localparam int unsigned IN_W  = 32;
    localparam int unsigned RATIO = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OUT_W = IN_W * RATIO;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [RATIO-1:0] out_keep;
    logic             out_last;
    logic [2:0]       fifo_level;

    int checks;
    int failures;

    logic [OUT_W-1:0] q_data[$];
    logic [RATIO-1:0] q_keep[$];
    logic             q_last[$];
    logic [IN_W-1:0]  part[$];

    stream_pack_reader #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Compare all outputs against the model's current view of the FIFO.
    task automatic check_outputs(input string tag);
        int n;
        n = q_data.size();
        chk({tag, "_out_valid"}, OUT_W'(out_valid), OUT_W'(n != 0));
        chk({tag, "_in_ready"}, OUT_W'(in_ready), OUT_W'(n != DEPTH));
        chk({tag, "_level"}, OUT_W'(fifo_level), OUT_W'(n));
        chk({tag, "_data"}, out_data, (n != 0) ? q_data[0] : '0);
        chk({tag, "_keep"}, OUT_W'(out_keep), (n != 0) ? OUT_W'(q_keep[0]) : '0);
        chk({tag, "_last"}, OUT_W'(out_last), (n != 0) ? OUT_W'(q_last[0]) : '0);
    endtask

    // One clock cycle: check at negedge, drive, advance the model, wait for next negedge.
    task automatic step(input string tag, input logic v, input logic [IN_W-1:0] d,
                        input logic l, input logic r);
        logic             exp_ir;
        logic             exp_ov;
        logic [OUT_W-1:0] w;
        logic [RATIO-1:0] kp;
        check_outputs(tag);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        exp_ir = (q_data.size() != DEPTH);
        exp_ov = (q_data.size() != 0);
        if (exp_ov && r) begin
            void'(q_data.pop_front());
            void'(q_keep.pop_front());
            void'(q_last.pop_front());
        end
        if (v && exp_ir) begin
            part.push_back(d);
            if (part.size() == RATIO || l) begin
                w  = '0;
                kp = '0;
                foreach (part[k]) begin
                    w[k*IN_W +: IN_W] = part[k];
                    kp[k]             = 1'b1;
                end
                q_data.push_back(w);
                q_keep.push_back(kp);
                q_last.push_back(l);
                part.delete();
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset pulse away from any rising edge; outputs must clear immediately.
    task automatic do_reset();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", OUT_W'(out_valid), '0);
        chk("rst_in_ready", OUT_W'(in_ready), OUT_W'(1));
        chk("rst_level", OUT_W'(fifo_level), '0);
        chk("rst_data", out_data, '0);
        chk("rst_keep", OUT_W'(out_keep), '0);
        chk("rst_last", OUT_W'(out_last), '0);
        q_data.delete();
        q_keep.delete();
        q_last.delete();
        part.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Full word of four beats held with out_ready low.
        step("fw0", 1'b1, 32'h11111111, 1'b0, 1'b0);
        step("fw1", 1'b1, 32'h22222222, 1'b0, 1'b0);
        step("fw2", 1'b1, 32'h33333333, 1'b0, 1'b0);
        step("fw3", 1'b1, 32'h44444444, 1'b0, 1'b0);
        chk("full_word", out_data, 128'h44444444_33333333_22222222_11111111);
        chk("full_keep", OUT_W'(out_keep), OUT_W'(4'hF));
        chk("full_last", OUT_W'(out_last), '0);
        step("fw_pop", 1'b0, '0, 1'b0, 1'b1);

        // Early close by in_last, then next beat starts at lane 0.
        step("ec0", 1'b1, 32'hAAAA0001, 1'b0, 1'b0);
        step("ec1", 1'b1, 32'hAAAA0002, 1'b1, 1'b0);
        chk("early_word", out_data, 128'h00000000_00000000_AAAA0002_AAAA0001);
        chk("early_keep", OUT_W'(out_keep), OUT_W'(4'b0011));
        chk("early_last", OUT_W'(out_last), OUT_W'(1));
        step("ec2", 1'b1, 32'hBBBB0000, 1'b0, 1'b1);
        step("ec3", 1'b1, 32'hCCCC0001, 1'b1, 1'b1);
        chk("lane0_next", OUT_W'(out_data[31:0]), OUT_W'(32'hBBBB0000));
        step("ec_pop", 1'b0, '0, 1'b0, 1'b1);

        // Back-pressure: 16 beats fill the FIFO, the 17th is held until after a pop.
        for (int i = 0; i < 16; i++) begin
            step("bp", 1'b1, IN_W'(32'h0B000000 + i), 1'b0, 1'b0);
        end
        chk("bp_level_full", OUT_W'(fifo_level), OUT_W'(4));
        chk("bp_in_ready_low", OUT_W'(in_ready), '0);
        step("bp_hold", 1'b1, 32'h0B000010, 1'b0, 1'b0);
        step("bp_pop1", 1'b1, 32'h0B000010, 1'b0, 1'b1);
        chk("bp_level_after_pop", OUT_W'(fifo_level), OUT_W'(3));
        chk("bp_ready_after_pop", OUT_W'(in_ready), OUT_W'(1));
        step("bp_take17", 1'b1, 32'h0B000010, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step("bp_drain", 1'b0, '0, 1'b0, 1'b1);
        end

        // Mid-word reset with two words stored and a partial word pending.
        for (int i = 0; i < 9; i++) begin
            step("mr_fill", 1'b1, IN_W'(32'h0D000000 + i), 1'b0, 1'b0);
        end
        chk("mr_level_before", OUT_W'(fifo_level), OUT_W'(2));
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            step("mr_beat", 1'b1, IN_W'(i), 1'b0, 1'b0);
        end
        chk("mr_word", out_data, 128'h00000004_00000003_00000002_00000001);
        chk("mr_keep", OUT_W'(out_keep), OUT_W'(4'hF));
        step("mr_pop", 1'b0, '0, 1'b0, 1'b1);

        // Random traffic with varying back-pressure.
        for (int i = 0; i < 600; i++) begin
            step("rnd", ($urandom_range(0, 9) < 7), IN_W'($urandom),
                 ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 3 : 8)));
        end
        for (int i = 0; i < 8; i++) begin
            step("rnd_drain", 1'b0, '0, 1'b0, 1'b1);
        end
        check_outputs("end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_pack_reader.md
# stream_pack_reader

Parametrised input reader that accepts narrow data beats over a valid/ready handshake and packs them into wide words. Beats are packed little-endian, RATIO beats per word, and words are buffered in a DEPTH-entry FIFO. An in_last marker closes a word early and flags it. The block sits between a narrow external source and the wide (128-bit default) datapath, with back-pressure on both sides.

## Interface
Parameters:
- IN_W, 32, input beat width in bits.
- RATIO, 4, beats per output word, ≥2; OUT_W = IN_W*RATIO.
- DEPTH, 4, output FIFO entries, power of two, ≥2.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  source beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  IN_W  beat payload.
- in_last  in  1  beat closes the current word (end of frame).
- out_valid  out  1  FIFO head word valid.
- out_ready  in  1  sink accepts the head word.
- out_data  out  OUT_W  packed word; lane k = bits [k*IN_W +: IN_W].
- out_keep  out  RATIO  per-lane filled flags.
- out_last  out  1  word was closed by in_last.
- fifo_level  out  clog2(DEPTH)+1  words currently stored.

## Operation
- A beat is accepted when in_valid && in_ready.
- in_ready = (fifo_level != DEPTH). It uses the registered level only, so a pop in the same cycle does not raise it.
- Packing state:
  - lane index 0..RATIO-1.
  - pack register: OUT_W data plus RATIO keep bits.
- Each accepted beat:
  - is written to lane[index], and its keep bit is set;
  - then increments the index, unless the beat is closing.
- A beat is closing if index == RATIO-1 or in_last = 1.
- On a closing beat:
  - the word is written to the FIFO tail as {data incl. current beat, keep, in_last};
  - the pack register is cleared to zero, keep to 0, and index to 0.
- Unfilled lanes in a partial word are zero.
- in_last on lane RATIO-1 gives one full word with keep all ones and last = 1.
- FIFO behaviour:
  - circular buffer with rd/wr pointers of clog2(DEPTH) bits that wrap modulo DEPTH, plus the level counter.
  - Push and pop in the same cycle leave the level unchanged.
  - The level never exceeds DEPTH and never underflows.
- Pop: when out_valid && out_ready, advance the read pointer.
- Output driving:
  - out_valid = (fifo_level != 0).
  - out_data, out_keep and out_last come from the head entry when out_valid = 1, and are forced to 0 otherwise.
- Sink-side rule: out_data, out_keep and out_last hold stable while out_valid = 1 and out_ready = 0.
- Source-side rule: the block places no requirements on the source beyond the handshake. in_valid may drop without a transfer.
- Reset:
  - Any time rst is asserted, including mid-word or mid-drain: index 0, pack register 0, pointers 0, level 0.
  - Stored words and partial words are discarded.
  - Output values during reset: out_valid = 0, out_data = 0, out_keep = 0, out_last = 0, fifo_level = 0, in_ready = 1.

## Timing
- Latency: a closing beat accepted at edge N makes the word visible with out_valid = 1 after edge N; the sink can take it at edge N+1.
- Throughput: one beat per cycle in; one word per cycle out.
- Full FIFO: in_ready = 0. A pop at edge N gives in_ready = 1 after edge N, so there is one bubble cycle.
- Empty FIFO plus a push: there is no bypass; out_valid rises the cycle after the push.
- Reset: rst is asynchronous on assert; logic resumes on the first clk edge after deassert.

## Test plan
- Reset:
  - Stimulus: assert rst, then release.
  - Response: out_valid = 0, in_ready = 1, fifo_level = 0, out_data = 0.
- Full word (IN_W=32, RATIO=4), out_ready = 1:
  - Stimulus: beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 with in_last = 0.
  - Response: word 0x44444444_33333333_22222222_11111111, out_keep = 4'hF, out_last = 0, out_valid high exactly one cycle after the 4th beat.
- Early close:
  - Stimulus: beats 0xAAAA0001, then 0xAAAA0002 with in_last = 1, followed by beat 0xBBBB0000.
  - Response: first word {0, 0, 0xAAAA0002, 0xAAAA0001}, out_keep = 4'b0011, out_last = 1. 0xBBBB0000 lands in lane 0 of the next word.
- Back-pressure:
  - Stimulus: out_ready = 0, stream 17 beats.
  - Response: fifo_level = 4 after the 16th beat; in_ready = 0 and the 17th beat is held. Raising out_ready drains 4 words in order, and the 17th beat is accepted one cycle after the first pop.
- Full with simultaneous events:
  - Stimulus: level = 4, out_ready = 1, in_valid = 1.
  - Response: pop only (level 3, beat not accepted); the beat is accepted the next cycle.
- Mid-word reset:
  - Stimulus: 2 beats accepted, then rst pulsed while out_ready = 0 with 2 words stored; then 4 beats 1, 2, 3, 4.
  - Response: after reset, level = 0 and index = 0. The next word is 0x00000004_00000003_00000002_00000001 with keep 4'hF.
